// File: rtl/enjens_pkg.sv
// rtl/enjens_pkg.sv - command codes and reset constants for the enjens timer/PWM tile
package enjens_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'b000,
    CMD_PERIOD   = 3'b001,
    CMD_DUTY     = 3'b010,
    CMD_START    = 3'b011,
    CMD_STOP     = 3'b100,
    CMD_CLEAR    = 3'b101,
    CMD_PRESCALE = 3'b110,
    CMD_NOP2     = 3'b111
  } cmd_e;

  localparam logic [7:0] PERIOD_RST = 8'hFF;
  localparam logic [7:0] DUTY_RST   = 8'h80;
  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/enjens_counter.sv
// rtl/enjens_counter.sv - count/wrap datapath with optional prescaler (ENJENS_PRESCALE_EN)
module enjens_counter
  import enjens_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       run,
  input  logic       clear,
  input  logic [7:0] period,
`ifdef ENJENS_PRESCALE_EN
  input  logic [7:0] prescale,
`endif
  output logic [7:0] count,
  output logic       wrap
);

  logic terminal;
  logic tick;

`ifdef ENJENS_PRESCALE_EN
  logic [7:0] pre_cnt;

  assign terminal = (pre_cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 8'd0;
    end else if (ena) begin
      if (clear) begin
        pre_cnt <= 8'd0;
      end else if (run) begin
        pre_cnt <= terminal ? 8'd0 : pre_cnt + 8'd1;
      end
    end
  end
`else
  assign terminal = 1'b1;
`endif

  assign tick = run && ena && terminal;

  // wrap is a single-cycle pulse, so it drops even while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ena && clear) begin
        count <= 8'd0;
      end else if (tick) begin
        if (count >= period) begin
          count <= 8'd0;
          wrap  <= 1'b1;
        end else begin
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/enjens.sv
// rtl/enjens.sv - timer/PWM tile top: command decode, duty, pwm; prescaler under ENJENS_PRESCALE_EN
module enjens
  import enjens_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [7:0] period;
  logic [7:0] duty;
  logic       running;
  logic       strobe_q;
  logic       cmd_fire;
  logic       clear;
  logic       pwm;
  logic       wrap;
  logic [7:0] count;
  cmd_e       cmd;
  logic       unused_uio;

  assign cmd        = cmd_e'(uio_in[2:0]);
  assign cmd_fire   = ena && uio_in[3] && !strobe_q;
  assign clear      = cmd_fire && (cmd == CMD_CLEAR);
  assign unused_uio = ^uio_in[7:4];

`ifdef ENJENS_PRESCALE_EN
  logic [7:0] prescale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 8'd0;
    end else if (cmd_fire && cmd == CMD_PRESCALE) begin
      prescale <= ui_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period   <= PERIOD_RST;
      duty     <= DUTY_RST;
      running  <= 1'b0;
      strobe_q <= 1'b0;
    end else if (ena) begin
      strobe_q <= uio_in[3];
      if (cmd_fire) begin
        case (cmd)
          CMD_PERIOD: period  <= ui_in;
          CMD_DUTY:   duty    <= ui_in;
          CMD_START:  running <= 1'b1;
          CMD_STOP:   running <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  enjens_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (running),
    .clear    (clear),
    .period   (period),
`ifdef ENJENS_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .wrap     (wrap)
  );

  assign pwm     = running && (count < duty);
  assign uo_out  = count;
  assign uio_out = {1'b0, running, wrap, pwm, 4'b0000};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_enjens.sv
// tb/tb_enjens.sv - scoreboard bench for enjens with a behavioural timer model
module tb_enjens;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  enjens dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] uio;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // model state: what the timer should hold after each clock
  int   m_period, m_duty, m_count, m_presc, m_pre;
  bit   m_run, m_sq, m_wrap;

  task automatic m_reset();
    m_period = 255; m_duty = 128; m_count = 0; m_presc = 0; m_pre = 0;
    m_run = 0; m_sq = 0; m_wrap = 0;
  endtask

  task automatic m_step(input bit e, input int u, input int io);
    bit fire, clr, term, tick;
    int code;
    code = io & 7;
    fire = e && ((io >> 3) & 1) && !m_sq;
    clr  = fire && code == 5;
`ifdef ENJENS_PRESCALE_EN
    term = (m_pre == m_presc);
`else
    term = 1;
`endif
    tick = m_run && e && term;
    m_wrap = 0;
    if (clr) m_count = 0;
    else if (tick) begin
      if (m_count >= m_period) begin m_count = 0; m_wrap = 1; end
      else m_count = m_count + 1;
    end
    if (e) begin
      if (clr) m_pre = 0;
      else if (m_run) m_pre = term ? 0 : m_pre + 1;
      m_sq = ((io >> 3) & 1);
    end
    if (fire) begin
      case (code)
        1: m_period = u;
        2: m_duty = u;
        3: m_run = 1;
        4: m_run = 0;
`ifdef ENJENS_PRESCALE_EN
        6: m_presc = u;
`endif
        default: ;
      endcase
    end
  endtask

  function automatic exp_t m_expect();
    exp_t x;
    x.cnt = 8'(m_count);
    x.uio = {1'b0, m_run, m_wrap, (m_run && m_count < m_duty), 4'b0000};
    return x;
  endfunction

  task automatic cyc(input bit e, input logic [7:0] u, input logic [7:0] io);
    ena = e; ui_in = u; uio_in = io;
    @(posedge clk);
    m_step(e, int'(u), int'(io));
    q.push_back(m_expect());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'd0, 8'd0);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [7:0] d);
    cyc(1'b1, d, {4'b0000, 1'b1, c});
    cyc(1'b1, d, {4'b0000, 1'b0, c});
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total++;
      if (uo_out !== x.cnt || uio_out !== x.uio || uio_oe !== 8'hF0) begin
        bad++;
        $display("FAIL cycle @%0t: uo_out=%h uio_out=%h uio_oe=%h want %h %h f0",
                 $time, uo_out, uio_out, uio_oe, x.cnt, x.uio);
      end
    end
  end

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hF0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'hF0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // default period: full 0..255 sweep and wrap
    cmd(3'd3, 8'd0);
    idle(262);

    // period 4, duty 2
    cmd(3'd4, 8'd0); cmd(3'd5, 8'd0);
    cmd(3'd1, 8'd4); cmd(3'd2, 8'd2); cmd(3'd3, 8'd0);
    idle(15);

    // held strobe with code change: only START executes
    cmd(3'd4, 8'd0); cmd(3'd5, 8'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd0, 8'h0B);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd0, 8'h0C);
    idle(4);

    // stop, hold, resume, clear while running
    cmd(3'd4, 8'd0); idle(5); cmd(3'd3, 8'd0); idle(3);
    cmd(3'd5, 8'd0); idle(3);

    // duty extremes and ena freeze
    cmd(3'd2, 8'd0); idle(8);
    cmd(3'd2, 8'hFF); idle(8);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0, 8'h0D);
    idle(4);

    // period 0 and period loaded below count
    cmd(3'd1, 8'd0); idle(4);
    cmd(3'd1, 8'd9); idle(8); cmd(3'd1, 8'd2); idle(5);

    // prescale 2, period 1 (cmd 110 is a no-op without the prescaler)
    cmd(3'd4, 8'd0); cmd(3'd5, 8'd0);
    cmd(3'd6, 8'd2); cmd(3'd1, 8'd1); cmd(3'd3, 8'd0);
    idle(14);

    async_reset();
    cmd(3'd1, 8'd3); cmd(3'd3, 8'd0); idle(6);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        logic [2:0] c;
        logic [7:0] d;
        c = 3'($urandom_range(0, 7));
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
        cmd(c, d);
      end else if (r == 2) begin
        cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      end else begin
        cyc($urandom_range(0, 9) != 0, 8'd0, 8'd0);
      end
      if (i == 700) async_reset();
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enjens.md
# enjens

Programmable 8-bit timer/PWM generator for the TinyTapeout user slot. An external controller loads period, duty and (optionally) prescale registers through a strobed command port, then starts or stops counting. The block exposes the live count, a PWM output, a wrap pulse and a running flag. All outputs are on the standard tile pins.

## Interface
- No parameters.
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  tile enable; low freezes all state (no commands, no counting)
- ui_in  input  8  data operand for load commands
- uio_in  input  8  [2:0] command code, [3] strobe; [7:4] ignored
- uio_out  output  8  [4] pwm, [5] wrap, [6] running, [7] 0, [3:0] 0
- uio_oe  output  8  constant 8'hF0
- uo_out  output  8  current count

## Operation
- Registers: period (reset 8'hFF), duty (8'h80), count (0), running (0), strobe_q (0), wrap (0), prescale (0), pre_cnt (0).
- Command executes on a strobe rising edge: uio_in[3]=1 and strobe_q=0, with ena=1. strobe_q <= uio_in[3] every enabled cycle.
- Command codes: 000 NOP; 001 period <= ui_in; 010 duty <= ui_in; 011 running <= 1; 100 running <= 0; 101 count <= 0, pre_cnt <= 0; 110 prescale <= ui_in (see Configuration); 111 NOP.
- Tick: running && ena && prescaler terminal. On tick: if count >= period, count <= 0 and wrap <= 1; else count <= count+1. wrap is 0 in every cycle not following a wrapping tick.
- Clear (101) and a tick in the same cycle: clear wins; no wrap.
- Stop (100) holds count; start resumes from held value.
- pwm = running && (count < duty), combinational from registers. duty 0 -> always low; duty > period -> high while running.
- period 0: count stays 0, wrap every tick.
- Loading period below current count: next tick wraps to 0.

## Timing
- Command effect visible in registers/outputs one clock after the strobe-rising-edge cycle.
- Strobe held high executes once; must return low for at least one enabled cycle before the next command.
- Count advances one per tick; wrap is a one-cycle pulse coincident with count returning to 0.
- Async reset mid-operation: all registers return to reset values immediately; outputs uo_out=0, uio_out=0, uio_oe=8'hF0.

## Configuration
- ENJENS_PRESCALE_EN defined: prescaler active; pre_cnt counts 0..prescale while running; tick when pre_cnt == prescale, then pre_cnt <= 0. Count period = (prescale+1) clocks.
- Not defined: no prescale/pre_cnt registers; command 110 is a NOP; tick every enabled running cycle.

## Structure
- Package enjens_pkg: command code constants (CMD_NOP, CMD_PERIOD, CMD_DUTY, CMD_START, CMD_STOP, CMD_CLEAR, CMD_PRESCALE), reset constants (PERIOD_RST=8'hFF, DUTY_RST=8'h80), UIO_OE_VAL=8'hF0.
- Sub-module enjens_counter: count/wrap/prescaler datapath taking tick-enable, clear, period; top holds command decode, strobe edge detect, duty, pwm compare.

## Test plan
- Reset: after rst_n low, uo_out=0, uio_out=0, uio_oe=8'hF0; start with default period -> count reaches 255, wraps to 0 with wrap=1 one cycle.
- Load period=4, duty=2, start: count sequence 0,1,2,3,4,0…; pwm high on counts 0,1; wrap once per 5 clocks.
- Strobe held high 10 cycles with CMD_START then CMD_STOP code change: only the first command executes.
- Stop at count 3, wait 5 cycles, start: count resumes 3->4; clear during running -> count 0, wrap stays 0.
- duty=0 -> pwm always 0; duty=8'hFF with period=4 -> pwm constantly 1 while running; ena=0 freezes count.
- With ENJENS_PRESCALE_EN, prescale=2, period=1: count changes every 3 clocks; without macro, cmd 110 leaves count rate at 1 per clock.
